data_bus_bridge: RTL

Converts the CPU core's single-cycle data-RAM port (`ram_ce_o`/`ram_we_o`/`ram_sel_o`/`ram_addr_o`/`ram_data_o`/`ram_data_i`) into a registered valid/ready request plus response-valid bus, so data memory and peripherals may take multiple cycles. Sits directly downstream of the MEM stage, between the core top and the data-side interconnect. Holds the pipeline through `stallreq` while a transaction is outstanding, and drops or drains it on an exception flush. A response timeout keeps a dead slave from hanging the core.

---
 rtl/bus_pkg.sv | 26 ++
 rtl/data_bus_bridge_if.sv | 24 ++
 rtl/dbus_timeout.sv | 28 ++
 rtl/data_bus_bridge.sv | 121 ++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types and defaults for the data-side bus bridge.
package bus_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEL_W  = 4;

  localparam int unsigned       TIMEOUT_CYCLES_DEF = 255;
  localparam logic [DATA_W-1:0] ERR_RDATA_DEF      = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DONE,
    DRAIN
  } bridge_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/data_bus_bridge_if.sv
// Valid/ready request plus response-valid data bus between bridge and interconnect.
interface data_bus_bridge_if;
  import bus_pkg::*;

  logic              bus_req_valid;
  logic              bus_req_ready;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_we;
  logic [SEL_W-1:0]  bus_sel;
  logic              bus_resp_valid;
  logic [DATA_W-1:0] bus_resp_data;

  modport master (
    output bus_req_valid, bus_addr, bus_wdata, bus_we, bus_sel,
    input  bus_req_ready, bus_resp_valid, bus_resp_data
  );

  modport slave (
    input  bus_req_valid, bus_addr, bus_wdata, bus_we, bus_sel,
    output bus_req_ready, bus_resp_valid, bus_resp_data
  );

endinterface

// File: rtl/dbus_timeout.sv
// Saturating response-wait counter; expired flags the last allowed cycle.
module dbus_timeout #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != CNT_W'(LIMIT))) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired = (cnt >= CNT_W'(LIMIT - 1));

endmodule

// File: rtl/data_bus_bridge.sv
// Turns the core's single-cycle data-RAM port into a multi-cycle valid/ready bus,
// stalling the pipeline while one transaction is outstanding.
module data_bus_bridge
  import bus_pkg::*;
#(
  parameter int unsigned       TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter logic [DATA_W-1:0] ERR_RDATA      = ERR_RDATA_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              cpu_ce,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [SEL_W-1:0]  cpu_sel,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              stallreq,
  output logic              bus_err,
  data_bus_bridge_if.master bus
);

  bridge_state_t state;
  bus_req_t      req_q;
  logic          req_valid_q;
  logic          tmo_clear;
  logic          tmo_en;
  logic          tmo_expired;

  assign tmo_clear = (state == REQ) && bus.bus_req_ready;
  assign tmo_en    = (state == WAIT) || (state == DRAIN);

  dbus_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmo_clear),
    .enable  (tmo_en),
    .expired (tmo_expired)
  );

  // Request, response and state registers; bus regs only load on IDLE->REQ.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      req_q       <= '0;
      req_valid_q <= 1'b0;
      cpu_rdata   <= '0;
      bus_err     <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_ce && !flush) begin
            req_q.addr  <= cpu_addr;
            req_q.we    <= cpu_we;
            req_q.sel   <= cpu_sel;
            req_q.wdata <= cpu_wdata;
            req_valid_q <= 1'b1;
            state       <= REQ;
          end
        end
        REQ: begin
          if (bus.bus_req_ready) begin
            req_valid_q <= 1'b0;
            state       <= flush ? DRAIN : WAIT;
          end else if (flush) begin
            req_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        WAIT: begin
          // A flush coinciding with completion leaves nothing to drain.
          if (flush) begin
            state <= (bus.bus_resp_valid || tmo_expired) ? IDLE : DRAIN;
          end else if (bus.bus_resp_valid) begin
            cpu_rdata <= bus.bus_resp_data;
            state     <= DONE;
          end else if (tmo_expired) begin
            cpu_rdata <= ERR_RDATA;
            bus_err   <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        DRAIN: begin
          if (bus.bus_resp_valid || tmo_expired) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.bus_req_valid = req_valid_q;
  assign bus.bus_addr      = req_q.addr;
  assign bus.bus_we        = req_q.we;
  assign bus.bus_sel       = req_q.sel;
  assign bus.bus_wdata     = req_q.wdata;

  // Stall must react in the same cycle the MEM stage raises cpu_ce.
  always_comb begin
    stallreq = 1'b0;
    case (state)
      IDLE:      stallreq = cpu_ce && !flush;
      REQ, WAIT: stallreq = 1'b1;
      DRAIN:     stallreq = cpu_ce;
      default:   stallreq = 1'b0;
    endcase
    if (!rst) begin
      stallreq = 1'b0;
    end
  end

endmodule
